// File: rtl/mem_io_pkg.sv
// Shared address map, STATUS bit positions and IO decode helpers for the memory/IO bridge.
package mem_io_pkg;

  localparam logic [31:0] IO_DATA_A = 32'h0003_0000;
  localparam logic [31:0] IO_STAT_A = 32'h0003_0004;
  localparam logic [31:0] IO_CNT_A  = 32'h0003_0008;

  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_TX_OVF   = 2;
  localparam int STAT_RX_OVF   = 3;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STAT,
    REG_CNT
  } io_reg_e;

  // IO window is selected by address bits 17:16 alone; everything else goes to RAM.
  function automatic logic is_io(input logic [31:0] addr);
    return (addr & 32'h0003_0000) == 32'h0003_0000;
  endfunction

  function automatic io_reg_e decode_reg(input logic [31:0] addr);
    if (addr == IO_DATA_A) return REG_DATA;
    if (addr == IO_STAT_A) return REG_STAT;
    if (addr[31:2] == IO_CNT_A[31:2]) return REG_CNT;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU byte-wide memory port bundle: address, write byte, write strobe and 1-cycle read byte.
interface mem_io_bridge_if;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_wn;
  logic        cpu_wr;
  logic [7:0]  cpu_rn;

  modport master (output cpu_a, output cpu_wn, output cpu_wr, input  cpu_rn);
  modport slave  (input  cpu_a, input  cpu_wn, input  cpu_wr, output cpu_rn);
endinterface

// File: rtl/mem_io_bridge_byte_fifo.sv
// Byte FIFO with log2(DEPTH)+1 bit pointers; the extra MSB distinguishes full from empty.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_reg [DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU byte-port decoder: RAM or a UART-style byte IO window, fixed 1-cycle read latency.
// Optional MEM_IO_CYCLE_CNT_EN adds a snapshot-coherent 32-bit cycle counter at 0x30008..0x3000B.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_io_bridge_if.slave    cpu,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_wn,
  output logic              ram_we,
  input  logic [7:0]        ram_rn,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  io_reg_e    reg_sel;
  logic       io, data_rd, data_rd_prev_reg;
  logic       tx_push, tx_pop, tx_drop, rx_pop, rx_drop, ovf_clr;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] rx_dout, stat_byte, cnt_byte, io_next;
  logic       tx_ovf_reg, rx_ovf_reg;
  logic       sel_q;
  logic [7:0] io_q;

  assign io      = is_io(cpu.cpu_a);
  assign reg_sel = decode_reg(cpu.cpu_a);
  assign ram_a   = cpu.cpu_a[RAM_AW-1:0];
  assign ram_wn  = cpu.cpu_wn;
  assign ram_we  = cpu.cpu_wr & ~io;

  // A DATA read held over several cycles pops only on its first cycle.
  assign data_rd = io & ~cpu.cpu_wr & (reg_sel == REG_DATA);
  assign rx_pop  = data_rd & ~data_rd_prev_reg & ~rx_empty;
  assign rx_drop = rx_valid & rx_full & ~rx_pop;

  assign tx_push = io & cpu.cpu_wr & (reg_sel == REG_DATA);
  assign tx_pop  = ~tx_empty & tx_ready;
  assign tx_drop = tx_push & tx_full & ~tx_pop;
  assign ovf_clr = io & cpu.cpu_wr & (reg_sel == REG_STAT) & cpu.cpu_wn[0];

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign cpu.cpu_rn = sel_q ? io_q : ram_rn;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (cpu.cpu_wn),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    stat_byte                = 8'h00;
    stat_byte[STAT_RX_EMPTY] = rx_empty;
    stat_byte[STAT_TX_FULL]  = tx_full;
    stat_byte[STAT_TX_OVF]   = tx_ovf_reg;
    stat_byte[STAT_RX_OVF]   = rx_ovf_reg;
  end

`ifdef MEM_IO_CYCLE_CNT_EN
  logic [31:0] cnt_reg, snap_reg;
  logic        cnt_rd0;

  // Byte0 read latches the whole count so bytes 1..3 come from the same instant.
  assign cnt_rd0 = io & ~cpu.cpu_wr & (reg_sel == REG_CNT) & (cpu.cpu_a[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      snap_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 32'd1;
      if (cnt_rd0) snap_reg <= cnt_reg;
    end
  end

  always_comb begin
    cnt_byte = 8'h00;
    case (cpu.cpu_a[1:0])
      2'd0:    cnt_byte = cnt_reg[7:0];
      2'd1:    cnt_byte = snap_reg[15:8];
      2'd2:    cnt_byte = snap_reg[23:16];
      default: cnt_byte = snap_reg[31:24];
    endcase
  end
`else
  assign cnt_byte = 8'h00;
`endif

  always_comb begin
    io_next = 8'h00;
    if (io && !cpu.cpu_wr) begin
      case (reg_sel)
        REG_DATA: io_next = rx_empty ? 8'h00 : rx_dout;
        REG_STAT: io_next = stat_byte;
        REG_CNT:  io_next = cnt_byte;
        default:  io_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q            <= 1'b1;
      io_q             <= 8'h00;
      data_rd_prev_reg <= 1'b0;
      tx_ovf_reg       <= 1'b0;
      rx_ovf_reg       <= 1'b0;
    end else begin
      sel_q            <= io;
      io_q             <= io_next;
      data_rd_prev_reg <= data_rd;
      // A new overflow in the same cycle as a clear stays visible.
      if (ovf_clr) begin
        tx_ovf_reg <= 1'b0;
        rx_ovf_reg <= 1'b0;
      end
      if (tx_drop) tx_ovf_reg <= 1'b1;
      if (rx_drop) rx_ovf_reg <= 1'b1;
    end
  end

endmodule
